// File: rtl/core_result_collector_pkg.sv
// Shared types and constants for the per-core result collector.
// Word0 layout: {core_id, 6'b0, hdr, status}.
package core_result_pkg;

    typedef enum logic [2:0] {
        S_HDR,
        S_STAT,
        S_DATA,
        S_W0,
        S_W1
    } state_t;

    localparam int STAT_EQUAL   = 1;
    localparam int STAT_BATCH   = 0;
    localparam int HDR_START    = 0;
    localparam int NIBBLES_DATA = 4;

    localparam int W0_ID_LSB   = 12;
    localparam int W0_HDR_LSB  = 2;
    localparam int W0_STAT_LSB = 0;

    function automatic logic [15:0] pack_word0(
        input logic [3:0] id,
        input logic [3:0] hdr,
        input logic [1:0] stat
    );
        logic [15:0] w;
        w = '0;
        w[W0_ID_LSB   +: 4] = id;
        w[W0_HDR_LSB  +: 4] = hdr;
        w[W0_STAT_LSB +: 2] = stat;
        return w;
    endfunction

endpackage

// File: rtl/core_result_collector_if.sv
// Nibble-in / word-out handshake bundle of the result collector.
// master = collector side, slave = buffer/FIFO side.
interface core_result_collector_if;

    logic [3:0]  din;
    logic        empty;
    logic        rd_en;
    logic [15:0] dout;
    logic        wr_en;
    logic        full;

    modport master (
        input  din,
        input  empty,
        input  full,
        output rd_en,
        output dout,
        output wr_en
    );

    modport slave (
        output din,
        output empty,
        output full,
        input  rd_en,
        input  dout,
        input  wr_en
    );

endinterface

// File: rtl/core_result_collector_sat_counter.sv
// Width-parameterised incrementer that sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/core_result_collector.sv
// Drains 4-bit result records, rebuilds them into tagged 16-bit words
// and keeps per-core result/batch statistics plus a sticky error flag.
module core_result_collector
    import core_result_pkg::*;
#(
    parameter logic [3:0] CORE_ID   = 4'h0,
    parameter int         CNT_WIDTH = 16
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    core_result_collector_if.master bus,
    output logic [CNT_WIDTH-1:0]   cnt_equal,
    output logic [CNT_WIDTH-1:0]   cnt_batch,
    output logic                   err_proto,
    output logic                   idle
);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_hdr;
    logic [1:0]  r_stat;
    logic [15:0] r_data;
    logic [1:0]  r_nib_cnt;
    logic [15:0] r_dout;
    logic        r_wr_en;
    logic        r_err;

    logic w_pop;
    logic w_wr0;
    logic w_wr1;
    logic w_last_nib;
    logic w_inc_equal;
    logic w_inc_batch;

    // Only the three read states may pop; write states hold off upstream.
    assign w_pop = ~bus.empty
                 & ((r_state == S_HDR)
                 |  (r_state == S_STAT)
                 |  (r_state == S_DATA));

    assign w_wr0      = (r_state == S_W0) & ~bus.full;
    assign w_wr1      = (r_state == S_W1) & ~bus.full;
    assign w_last_nib = (r_nib_cnt == 2'(NIBBLES_DATA - 1));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_HDR: begin
                if (w_pop && bus.din[HDR_START]) begin
                    w_next = S_STAT;
                end
            end
            S_STAT: begin
                if (w_pop) begin
                    w_next = bus.din[STAT_EQUAL] ? S_DATA : S_W0;
                end
            end
            S_DATA: begin
                if (w_pop && w_last_nib) begin
                    w_next = S_W0;
                end
            end
            S_W0: begin
                if (!bus.full) begin
                    w_next = r_stat[STAT_EQUAL] ? S_W1 : S_HDR;
                end
            end
            S_W1: begin
                if (!bus.full) begin
                    w_next = S_HDR;
                end
            end
            default: w_next = S_HDR;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_hdr     <= '0;
            r_stat    <= '0;
            r_data    <= '0;
            r_nib_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if ((r_state == S_HDR) && w_pop) begin
                r_hdr <= bus.din;
                if (!bus.din[HDR_START]) begin
                    r_err <= 1'b1;
                end
            end
            // A 00 status is flagged but the record is still emitted.
            if ((r_state == S_STAT) && w_pop) begin
                r_stat    <= bus.din[1:0];
                r_nib_cnt <= '0;
                if (bus.din[1:0] == 2'b00) begin
                    r_err <= 1'b1;
                end
            end
            if ((r_state == S_DATA) && w_pop) begin
                r_data[{r_nib_cnt, 2'b00} +: 4] <= bus.din;
                r_nib_cnt <= r_nib_cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_dout  <= '0;
            r_wr_en <= 1'b0;
        end else begin
            r_wr_en <= w_wr0 | w_wr1;
            if (w_wr0) begin
                r_dout <= pack_word0(CORE_ID, r_hdr, r_stat);
            end else if (w_wr1) begin
                r_dout <= r_data;
            end
        end
    end

    assign w_inc_equal = w_wr0 & r_stat[STAT_EQUAL];
    assign w_inc_batch = w_wr0 & r_stat[STAT_BATCH];

    sat_counter #(
        .W (CNT_WIDTH)
    ) u_cnt_equal (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_inc   (w_inc_equal),
        .o_cnt   (cnt_equal)
    );

    sat_counter #(
        .W (CNT_WIDTH)
    ) u_cnt_batch (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_inc   (w_inc_batch),
        .o_cnt   (cnt_batch)
    );

    assign bus.rd_en = w_pop;
    assign bus.dout  = r_dout;
    assign bus.wr_en = r_wr_en;
    assign err_proto = r_err;
    assign idle      = (r_state == S_HDR);

endmodule

// File: tb/tb_core_result_collector.sv
// Scoreboard bench: two collectors (ID 0 / 16-bit counters, ID A / 2-bit
// counters) fed the same nibble stream, each checked against its own model.
module tb_core_result_collector;

    logic CLK = 1'b0;
    logic RESET_N;

    always #5 CLK = ~CLK;

    core_result_collector_if bus0 ();
    core_result_collector_if bus1 ();

    logic [15:0] ceq0, cba0;
    logic [1:0]  ceq1, cba1;
    logic        err0, err1, idle0, idle1;

    core_result_collector #(
        .CORE_ID   (4'h0),
        .CNT_WIDTH (16)
    ) u_dut0 (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .bus       (bus0),
        .cnt_equal (ceq0),
        .cnt_batch (cba0),
        .err_proto (err0),
        .idle      (idle0)
    );

    core_result_collector #(
        .CORE_ID   (4'hA),
        .CNT_WIDTH (2)
    ) u_dut1 (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .bus       (bus1),
        .cnt_equal (ceq1),
        .cnt_batch (cba1),
        .err_proto (err1),
        .idle      (idle1)
    );

    logic [3:0]  q0[$];
    logic [3:0]  q1[$];
    logic [15:0] exp0[$];
    logic [15:0] exp1[$];
    logic [15:0] e0, e1;

    int checks   = 0;
    int failures = 0;
    int pops0    = 0;
    int wr0      = 0;
    int wr1      = 0;
    int m_eq0, m_ba0, m_eq1, m_ba1;
    logic m_err;

    // Upstream buffer model: pop on the edge, present next nibble on negedge.
    always @(posedge CLK) begin
        if (bus0.rd_en === 1'b1 && q0.size() > 0) begin
            void'(q0.pop_front());
            pops0++;
        end
        if (bus1.rd_en === 1'b1 && q1.size() > 0) begin
            void'(q1.pop_front());
        end
    end

    always @(negedge CLK) begin
        bus0.empty = (q0.size() == 0);
        bus0.din   = (q0.size() > 0) ? q0[0] : 4'h0;
        bus1.empty = (q1.size() == 0);
        bus1.din   = (q1.size() > 0) ? q1[0] : 4'h0;
    end

    always @(negedge CLK) begin
        if (RESET_N === 1'b1 && bus0.wr_en === 1'b1) begin
            checks++;
            wr0++;
            if (exp0.size() == 0) begin
                failures++;
                $display("FAIL sb0_extra got=%h expected=none", bus0.dout);
            end else begin
                e0 = exp0.pop_front();
                if (bus0.dout !== e0) begin
                    failures++;
                    $display("FAIL sb0_word got=%h expected=%h", bus0.dout, e0);
                end
            end
        end
        if (RESET_N === 1'b1 && bus1.wr_en === 1'b1) begin
            checks++;
            wr1++;
            if (exp1.size() == 0) begin
                failures++;
                $display("FAIL sb1_extra got=%h expected=none", bus1.dout);
            end else begin
                e1 = exp1.pop_front();
                if (bus1.dout !== e1) begin
                    failures++;
                    $display("FAIL sb1_word got=%h expected=%h", bus1.dout, e1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic set_full(input logic v);
        bus0.full = v;
        bus1.full = v;
    endtask

    task automatic push_nib(input logic [3:0] n);
        q0.push_back(n);
        q1.push_back(n);
    endtask

    task automatic push_rec(input logic [3:0] h, input logic [1:0] s,
                            input logic [15:0] d);
        push_nib(h);
        push_nib({2'b00, s});
        exp0.push_back({4'h0, 6'b0, h, s});
        exp1.push_back({4'hA, 6'b0, h, s});
        if (s[1]) begin
            for (int i = 0; i < 4; i++) push_nib(d[4*i +: 4]);
            exp0.push_back(d);
            exp1.push_back(d);
            m_eq0++;
            m_eq1 = (m_eq1 < 3) ? m_eq1 + 1 : 3;
        end
        if (s[0]) begin
            m_ba0++;
            m_ba1 = (m_ba1 < 3) ? m_ba1 + 1 : 3;
        end
        if (s == 2'b00) m_err = 1'b1;
    endtask

    task automatic clear_model();
        q0.delete();
        q1.delete();
        exp0.delete();
        exp1.delete();
        m_eq0 = 0;
        m_ba0 = 0;
        m_eq1 = 0;
        m_ba1 = 0;
        m_err = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RESET_N = 1'b0;
        clear_model();
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || exp0.size() != 0 ||
                exp1.size() != 0 || idle0 !== 1'b1 || idle1 !== 1'b1) &&
               n < 300) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL %s_drain got=timeout expected=drained q=%0d exp=%0d",
                     name, q0.size(), exp0.size());
        end
    endtask

    task automatic test_reset();
        int n = 0;
        logic [38:0] rst_exp = {1'b0, 1'b0, 16'h0, 1'b1, 2'b0, 2'b0, 16'h0, 1'b0};
        RESET_N = 1'b0;
        clear_model();
        repeat (2) @(negedge CLK);
        checks++;
        if ({bus0.rd_en, bus0.wr_en, bus0.dout, idle0, ceq1, cba1,
             ceq0, err0} !== rst_exp) begin
            failures++;
            $display("FAIL por_state got=%b expected=%b",
                     {bus0.rd_en, bus0.wr_en, bus0.dout, idle0, ceq1, cba1,
                      ceq0, err0}, rst_exp);
        end
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        push_nib(4'h1);
        push_nib(4'h2);
        push_nib(4'h4);
        push_nib(4'h3);
        while (pops0 < 4 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        checks++;
        if (idle0 !== 1'b0 || wr0 != 0 || n >= 50) begin
            failures++;
            $display("FAIL mid_record got=idle%b wr%0d pops%0d expected=idle0 wr0 pops4",
                     idle0, wr0, pops0);
        end
        #2;
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({bus1.rd_en, bus1.wr_en, bus1.dout, idle1, ceq1, cba1,
             cba0, err1} !== rst_exp) begin
            failures++;
            $display("FAIL async_rst got=%b expected=%b",
                     {bus1.rd_en, bus1.wr_en, bus1.dout, idle1, ceq1, cba1,
                      cba0, err1}, rst_exp);
        end
        clear_model();
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        n = wr0;
        push_rec(4'h1, 2'b10, 16'h1234);
        wait_drain("rst");
        checks++;
        if ({ceq0, cba0, ceq1, cba1, err0, err1} !==
            {16'(m_eq0), 16'(m_ba0), 2'(m_eq1), 2'(m_ba1), m_err, m_err} ||
            wr0 - n != 2) begin
            failures++;
            $display("FAIL rst_stats got=%0d/%0d/%0d/%0d/%b/%b w%0d expected=%0d/%0d/%0d/%0d/%b w2",
                     ceq0, cba0, ceq1, cba1, err0, err1, wr0 - n,
                     m_eq0, m_ba0, m_eq1, m_ba1, m_err);
        end
    endtask

    task automatic test_batch_only();
        int w0 = wr0;
        int w1 = wr1;
        push_rec(4'h1, 2'b01, 16'h0);
        wait_drain("batch");
        repeat (3) @(negedge CLK);
        checks++;
        if ({ceq0, cba0, ceq1, cba1, err0, err1} !==
            {16'(m_eq0), 16'(m_ba0), 2'(m_eq1), 2'(m_ba1), m_err, m_err} ||
            wr0 - w0 != 1 || wr1 - w1 != 1) begin
            failures++;
            $display("FAIL batch_stats got=%0d/%0d/%0d/%0d/%b w%0d/%0d expected=%0d/%0d/%0d/%0d/%b w1/1",
                     ceq0, cba0, ceq1, cba1, err0, wr0 - w0, wr1 - w1,
                     m_eq0, m_ba0, m_eq1, m_ba1, m_err);
        end
    endtask

    task automatic test_stall();
        int p = pops0;
        int w = wr0;
        int n = 0;
        set_full(1'b1);
        push_rec(4'h3, 2'b10, 16'hCDEF);
        while (pops0 < p + 6 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        push_rec(4'h1, 2'b01, 16'h0);
        repeat (5) @(posedge CLK);
        #1;
        checks++;
        if (pops0 != p + 6 || wr0 != w || n >= 50) begin
            failures++;
            $display("FAIL stall_w0 got=pops%0d wr%0d expected=pops%0d wr%0d",
                     pops0 - p, wr0 - w, 6, 0);
        end
        set_full(1'b0);
        @(posedge CLK);
        #1;
        set_full(1'b1);
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (pops0 != p + 6 || wr0 != w + 1) begin
            failures++;
            $display("FAIL stall_w1 got=pops%0d wr%0d expected=pops6 wr1",
                     pops0 - p, wr0 - w);
        end
        set_full(1'b0);
        wait_drain("stall");
        checks++;
        if (pops0 != p + 8 || wr0 != w + 3 ||
            {ceq0, cba0, ceq1, cba1} !==
            {16'(m_eq0), 16'(m_ba0), 2'(m_eq1), 2'(m_ba1)}) begin
            failures++;
            $display("FAIL stall_end got=pops%0d wr%0d eq%0d ba%0d expected=pops8 wr3 eq%0d ba%0d",
                     pops0 - p, wr0 - w, ceq0, cba0, m_eq0, m_ba0);
        end
    endtask

    task automatic test_zero_data();
        do_reset();
        push_rec(4'h1, 2'b11, 16'h0000);
        wait_drain("zero");
        checks++;
        if ({ceq0, cba0, ceq1, cba1, err0, err1} !==
            {16'd1, 16'd1, 2'd1, 2'd1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL zero_stats got=%0d/%0d/%0d/%0d/%b expected=1/1/1/1/0",
                     ceq0, cba0, ceq1, cba1, err0);
        end
    endtask

    task automatic test_bad_header();
        int w = wr0;
        push_nib(4'h0);
        m_err = 1'b1;
        push_rec(4'h1, 2'b01, 16'h0);
        wait_drain("badhdr");
        repeat (4) @(negedge CLK);
        checks++;
        if ({err0, err1} !== 2'b11 || wr0 - w != 1 ||
            {ceq0, cba0} !== {16'(m_eq0), 16'(m_ba0)}) begin
            failures++;
            $display("FAIL badhdr got=err%b%b wr%0d ba%0d expected=err11 wr1 ba%0d",
                     err0, err1, wr0 - w, cba0, m_ba0);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_rec(4'h1, 2'b10, 16'($urandom));
        end
        wait_drain("sat");
        checks++;
        if ({ceq0, ceq1, cba1, err0, err1} !==
            {16'd5, 2'd3, 2'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL sat_cnt got=%0d/%0d/%0d/%b%b expected=5/3/0/00",
                     ceq0, ceq1, cba1, err0, err1);
        end
        push_rec(4'h1, 2'b00, 16'h0);
        wait_drain("stat00");
        checks++;
        if ({ceq0, ceq1, err0, err1} !== {16'd5, 2'd3, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL stat00 got=%0d/%0d/%b%b expected=5/3/11",
                     ceq0, ceq1, err0, err1);
        end
    endtask

    initial begin
        set_full(1'b0);
        test_reset();
        test_batch_only();
        test_stall();
        test_zero_data();
        test_bad_header();
        test_saturate();
        repeat (2) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
